irq_capture_arbiter: RTL
========================

Name: irq_capture_arbiter

Overview:
- Sequential stage directly upstream of the team's 8-to-3 gate-level encoder.
- Captures rising edges on 8 request lines into sticky pending bits and selects exactly one eligible pending line.
- Drives that line as a registered one-hot vector straight into the encoder inputs i0..i7, plus a matching 3-bit code and valid/ready handshake for the consumer.
- Guarantees the encoder only ever sees zero or one asserted input.

Parameters:
RR_EN, 0, selection policy: 0 = fixed priority (highest index wins), 1 = round-robin.

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req  input  8  level request lines; rising edge creates a pending event
mask  input  8  1 = line not eligible for selection (pending still recorded)
grant_onehot  output  8  registered one-hot selection; bit k feeds encoder input ik
grant_code  output  3  binary index of grant_onehot
grant_valid  output  1  offer active; grant_onehot/grant_code valid
grant_ready  input  1  consumer accepts offer when high with grant_valid
pending  output  8  sticky pending register, for status

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset, sampled high at a clk edge:
  - pending = 0, grant_onehot = 0, grant_code = 0, grant_valid = 0, state = IDLE, rr_ptr = 7.
  - req_prev <= req, so lines already high at reset release produce no event.
  - Reset mid-offer drops the offer and all pending with no acceptance.
- Edge capture, every non-reset edge:
  - rise = req & ~req_prev; req_prev <= req.
  - pending <= (pending & ~clr) | rise.
  - Rise wins over clear on the same bit in the same cycle, so the bit stays set.
- eligible = pending & ~mask.
- FSM states:
  - IDLE: grant_valid = 0 and grant_onehot = 0. If eligible != 0, latch the selected index into grant regs, set grant_valid = 1, go to OFFER. Otherwise stay in IDLE.
  - OFFER: grant_onehot/grant_code/grant_valid are held stable while grant_ready = 0. Mask and req changes do not alter the held offer.
  - OFFER with grant_valid & grant_ready at an edge: clr = grant_onehot; grant_valid <= 0, grant_onehot <= 0; rr_ptr <= grant_code; go to IDLE.
- Throughput: minimum one IDLE bubble between consecutive grants, giving at most one grant per 2 cycles.
- Latency: req first sampled high at edge k sets pending after edge k. grant_valid is high after edge k+1 if that line is eligible and the FSM is in IDLE at edge k+1.
- Selection:
  - RR_EN = 0: the highest-index eligible bit wins.
  - RR_EN = 1: scan ascending from rr_ptr+1 mod 8 with wrap-around; the first eligible bit wins.
- Invariant: grant_onehot has at most one bit set and is all-zero when grant_valid = 0.
- Invariant: grant_code always equals the encoder's output for grant_onehot.
- A pending bit is never lost. A repeated rise on a bit that is already pending is absorbed, with no counting.
- Masked pending bits remain set indefinitely. Unmasking makes them selectable in the next IDLE cycle.

Test Plan:
- Reset with req = 8'h81 held high, then release -> no pending bits, grant_valid stays 0 for 10 cycles.
- RR_EN = 0: req 0 -> 8'h24 in one cycle, grant_ready = 1 -> grant_onehot 8'h20/code 5 first, IDLE bubble, then 8'h04/code 2, then pending = 0.
- RR_EN = 1: pending 8'h83 simultaneously, grant_ready = 1 -> grant order codes 0, 1, 7. A new rise on line 0 is then granted after 7 (wrap-around).
- Backpressure: offer code 3 with grant_ready = 0 for 5 cycles while mask changes to 8'h08 -> outputs stable all 5 cycles. Accept clears pending[3].
- Simultaneous clear and rise on the same line: accept line 6 on the same edge req[6] re-rises (after a low cycle) -> pending[6] remains 1, line 6 re-offered after the bubble.
- Reset asserted during OFFER with pending 8'hF0 -> all outputs 0 next cycle and no grant_ready acceptance effect.

Source files
------------

// File: rtl/irq_capture_arbiter_if.sv
// irq_capture_arbiter_if: request/mask inputs and one-hot grant handshake toward the encoder
interface irq_capture_arbiter_if;
    logic [7:0] req;
    logic [7:0] mask;
    logic [7:0] grant_onehot;
    logic [2:0] grant_code;
    logic       grant_valid;
    logic       grant_ready;
    logic [7:0] pending;
    modport master (
        input  req, mask, grant_ready,
        output grant_onehot, grant_code, grant_valid, pending
    );
    modport slave (
        output req, mask, grant_ready,
        input  grant_onehot, grant_code, grant_valid, pending
    );
endinterface

// File: rtl/irq_capture_arbiter.sv
// irq_capture_arbiter: captures request rising edges into sticky pending bits and offers one line at a time
module irq_capture_arbiter #(
    parameter bit RR_EN = 1'b0
) (
    input logic clk,
    input logic reset,
    irq_capture_arbiter_if.master bus
);
    typedef enum logic {IDLE, OFFER} state_t;
    state_t     state_q, state_d;
    logic [7:0] req_prev_q, pending_q, pending_d, onehot_q, onehot_d;
    logic [7:0] rise, clr, eligible;
    logic [2:0] code_q, code_d, rr_ptr_q, rr_ptr_d, sel, idx;
    logic       valid_q, valid_d, accept;

    assign rise      = bus.req & ~req_prev_q;
    assign accept    = (state_q == OFFER) && valid_q && bus.grant_ready;
    assign clr       = accept ? onehot_q : 8'd0;
    assign pending_d = (pending_q & ~clr) | rise;
    assign eligible  = pending_q & ~bus.mask;

    // Later loop iterations overwrite earlier ones, so the last hit is the winner
    always_comb begin
        sel = 3'd0;
        idx = 3'd0;
        if (RR_EN) begin
            for (int k = 8; k >= 1; k--) begin
                idx = rr_ptr_q + 3'(k);
                if (eligible[idx]) sel = idx;
            end
        end else begin
            for (int i = 0; i < 8; i++) if (eligible[i]) sel = 3'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        onehot_d = onehot_q;
        code_d   = code_q;
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE && eligible != 8'd0) begin
            state_d  = OFFER;
            onehot_d = 8'd1 << sel;
            code_d   = sel;
            valid_d  = 1'b1;
        end else if (accept) begin
            state_d  = IDLE;
            onehot_d = 8'd0;
            code_d   = 3'd0;
            valid_d  = 1'b0;
            rr_ptr_d = code_q;
        end
    end

    always_ff @(posedge clk) begin
        req_prev_q <= bus.req;
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= 8'd0;
            onehot_q  <= 8'd0;
            code_q    <= 3'd0;
            valid_q   <= 1'b0;
            rr_ptr_q  <= 3'd7;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            onehot_q  <= onehot_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign bus.grant_onehot = onehot_q;
    assign bus.grant_code   = code_q;
    assign bus.grant_valid  = valid_q;
    assign bus.pending      = pending_q;
endmodule
